// File: rtl/dmem_unit.sv
// Data-memory stage: lw/sw word access with a fixed multi-cycle latency.
// The CPU is held via stall while the access is in flight.
module dmem_unit #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        stall,
  output logic        ready,
  output logic [15:0] rdata,
  output logic        misaligned,
  output logic        req_error
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [AW:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [15:0] rdata_q;
  logic        req_err_q, req_err_d;
  logic        valid_req, access;

  logic [15:0] mem [DEPTH];

  assign valid_req = mem_read ^ mem_write;
  assign access    = (state_q == BUSY) && (cnt_q == 4'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    req_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        req_err_d = mem_read & mem_write;
        if (valid_req) begin
          addr_d  = addr[AW:0];
          wdata_d = wdata;
          we_d    = mem_write;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      req_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      req_err_q <= req_err_d;
      if (access && !we_q) rdata_q <= mem[addr_q[AW:1]];
    end
  end

  // Array is never cleared; a reset coinciding with the write edge blocks the write.
  always_ff @(posedge clock) begin
    if (!reset && access && we_q) mem[addr_q[AW:1]] <= wdata_q;
  end

  assign stall      = !reset && (((state_q == IDLE) && valid_req) || (state_q == BUSY));
  assign ready      = !reset && (state_q == DONE);
  assign misaligned = ready && addr_q[0];
  assign req_error  = !reset && req_err_q;
  assign rdata      = reset ? 16'h0000 : rdata_q;
endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: main instance at LATENCY=2 plus latency-sweep instances.
module tb_dmem_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] addr, wdata;
  logic        mem_read, mem_write;
  logic        stall, ready, misaligned, req_error;
  logic [15:0] rdata;

  logic        rd1, st1, rdy1, mis1, rerr1;
  logic        rd15, st15, rdy15, mis15, rerr15;
  logic [15:0] rdat1, rdat15;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_cnt = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    if (ready) ready_cnt++;
  end

  dmem_unit #(.DEPTH(256), .LATENCY(2)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .stall(stall), .ready(ready),
    .rdata(rdata), .misaligned(misaligned), .req_error(req_error));

  dmem_unit #(.DEPTH(256), .LATENCY(1)) dut_l1 (
    .clock(clock), .reset(reset), .addr(16'h0000), .wdata(16'h0000),
    .mem_read(rd1), .mem_write(1'b0), .stall(st1), .ready(rdy1),
    .rdata(rdat1), .misaligned(mis1), .req_error(rerr1));

  dmem_unit #(.DEPTH(256), .LATENCY(15)) dut_l15 (
    .clock(clock), .reset(reset), .addr(16'h0000), .wdata(16'h0000),
    .mem_read(rd15), .mem_write(1'b0), .stall(st15), .ready(rdy15),
    .rdata(rdat15), .misaligned(mis15), .req_error(rerr15));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CPU-style access: request held while stall is high; returns on DONE+1 with request cleared.
  task automatic acc(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                     output int ns, output logic rdy, output logic mis, output logic [15:0] rv);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    #1;
    ns = 0;
    while (stall && ns < 40) begin
      ns++;
      @(posedge clock); #2;
    end
    rdy = ready; mis = misaligned; rv = rdata;
    @(posedge clock); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_mis"},   misaligned, 0);
    chk({tag, "_rerr"},  req_error, 0);
  endtask

  initial begin
    int ns, n, c0, c1, c2, c3, c4, rc0;
    logic rdy, mis;
    logic [15:0] rv;

    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 16'h0; wdata = 16'h0;
    rd1 = 1'b0; rd15 = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk_zero("rst_held");
    mem_read = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    #1 chk_zero("rst_after");
    @(posedge clock); #1;

    // store then load
    acc(0, 1, 16'h0004, 16'h1234, ns, rdy, mis, rv);
    chk("sw_stall_cycles", ns, 3);
    chk("sw_ready", rdy, 1);
    chk("sw_rdata_kept", rv, 16'h0000);
    acc(1, 0, 16'h0004, 16'h0000, ns, rdy, mis, rv);
    chk("lw_stall_cycles", ns, 3);
    chk("lw_ready", rdy, 1);
    chk("lw_rdata", rv, 16'h1234);
    chk("lw_mis", mis, 0);

    // misaligned and aliasing
    acc(0, 1, 16'h0006, 16'hBEEF, ns, rdy, mis, rv);
    acc(1, 0, 16'h0007, 16'h0000, ns, rdy, mis, rv);
    chk("mis_rdata", rv, 16'hBEEF);
    chk("mis_flag", mis, 1);
    acc(1, 0, 16'h0206, 16'h0000, ns, rdy, mis, rv);
    chk("alias_rdata", rv, 16'hBEEF);
    chk("alias_mis", mis, 0);

    // illegal request
    mem_read = 1'b1; mem_write = 1'b1; addr = 16'h0004; wdata = 16'hFFFF;
    #1 chk("ill_stall", stall, 0);
    chk("ill_rerr_early", req_error, 0);
    @(posedge clock); #1 mem_read = 1'b0; mem_write = 1'b0;
    #1 chk("ill_rerr_pulse", req_error, 1);
    chk("ill_stall2", stall, 0);
    chk("ill_no_ready", ready, 0);
    @(posedge clock); #2 chk("ill_rerr_end", req_error, 0);
    chk("ill_rdata_kept", rdata, 16'hBEEF);
    @(posedge clock); #1;
    acc(1, 0, 16'h0004, 16'h0000, ns, rdy, mis, rv);
    chk("ill_mem_kept", rv, 16'h1234);

    // reset during the final BUSY cycle of a store
    acc(0, 1, 16'h0010, 16'h5555, ns, rdy, mis, rv);
    mem_write = 1'b1; addr = 16'h0010; wdata = 16'hAAAA;
    #1 chk("rms_stall", stall, 1);
    @(posedge clock); #1;
    @(posedge clock); #1 reset = 1'b1; mem_write = 1'b0;
    #1 chk_zero("rms_in_rst");
    @(posedge clock); #1 reset = 1'b0;
    #1 chk_zero("rms_after");
    @(posedge clock); #1;
    acc(1, 0, 16'h0010, 16'h0000, ns, rdy, mis, rv);
    chk("rms_mem_kept", rv, 16'h5555);

    // back-to-back accesses
    rc0 = ready_cnt; c0 = cyc;
    acc(0, 1, 16'h0000, 16'h0001, ns, rdy, mis, rv); c1 = cyc;
    acc(0, 1, 16'h0002, 16'h0002, ns, rdy, mis, rv); c2 = cyc;
    acc(1, 0, 16'h0000, 16'h0000, ns, rdy, mis, rv); c3 = cyc;
    chk("b2b_lw0", rv, 16'h0001);
    acc(1, 0, 16'h0002, 16'h0000, ns, rdy, mis, rv); c4 = cyc;
    chk("b2b_lw1", rv, 16'h0002);
    chk("b2b_span0", c1 - c0, 4);
    chk("b2b_span1", c2 - c1, 4);
    chk("b2b_span2", c3 - c2, 4);
    chk("b2b_span3", c4 - c3, 4);
    chk("b2b_ready_cnt", ready_cnt - rc0, 4);

    // latency sweep
    rd1 = 1'b1;
    #1 n = 0;
    while (st1 && n < 40) begin n++; @(posedge clock); #2; end
    chk("l1_stall_cycles", n, 2);
    chk("l1_ready", rdy1, 1);
    @(posedge clock); #1 rd1 = 1'b0;
    rd15 = 1'b1;
    #1 n = 0;
    while (st15 && n < 40) begin n++; @(posedge clock); #2; end
    chk("l15_stall_cycles", n, 16);
    chk("l15_ready", rdy15, 1);
    @(posedge clock); #1 rd15 = 1'b0;
    @(posedge clock); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
